// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the EX stage of a 5-stage MIPS core.
// Registers the EX operand forwarding selects and inserts one bubble per load-use hazard.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned NUM_ZERO_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_wreg,
    input  logic [REG_ADDR_W-1:0] id_waddr,
    input  logic                  id_is_load,
    input  logic                  hold,
    input  logic                  flush,
    output logic                  stall_id,
    output logic                  ex_valid,
    output logic                  control_rdata_a,
    output logic                  control_rdata_b,
    output logic                  state_lu
);

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_LU_BUBBLE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_ex_valid;
    logic                  r_ex_wreg;
    logic                  r_ex_is_load;
    logic [REG_ADDR_W-1:0] r_ex_waddr;
    logic                  r_sel_a;
    logic                  r_sel_b;

    logic [REG_ADDR_W-1:0] w_zero;
    logic                  w_ex_writes;
    logic                  w_hit_a;
    logic                  w_hit_b;
    logic                  w_stall;
    logic                  w_kill;

    assign w_zero      = REG_ADDR_W'(NUM_ZERO_REG);
    assign w_ex_writes = r_ex_valid & r_ex_wreg;

    assign w_hit_a = id_valid & id_use_rs & (id_rs != w_zero) & w_ex_writes & (r_ex_waddr == id_rs);
    assign w_hit_b = id_valid & id_use_rt & (id_rt != w_zero) & w_ex_writes & (r_ex_waddr == id_rt);

    assign w_stall = ~rst & (w_hit_a | w_hit_b) & r_ex_is_load & ~flush;
    assign w_kill  = flush | w_stall;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else if (w_stall) begin
            w_state_nxt = S_LU_BUBBLE;
        end else begin
            w_state_nxt = S_IDLE;
        end
    end

    // The producer in EX moves to MEM/WB on the same edge the select is registered,
    // so the EX slot alone determines forwarding; no separate MEM/WB slot is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ex_valid   <= 1'b0;
            r_ex_wreg    <= 1'b0;
            r_ex_is_load <= 1'b0;
            r_ex_waddr   <= '0;
            r_sel_a      <= 1'b0;
            r_sel_b      <= 1'b0;
        end else if (!hold) begin
            r_state <= w_state_nxt;
            if (w_kill) begin
                r_ex_valid   <= 1'b0;
                r_ex_wreg    <= 1'b0;
                r_ex_is_load <= 1'b0;
                r_ex_waddr   <= '0;
                r_sel_a      <= 1'b0;
                r_sel_b      <= 1'b0;
            end else begin
                r_ex_valid   <= id_valid;
                r_ex_wreg    <= id_wreg;
                r_ex_is_load <= id_is_load;
                r_ex_waddr   <= id_waddr;
                r_sel_a      <= w_hit_a & ~r_ex_is_load;
                r_sel_b      <= w_hit_b & ~r_ex_is_load;
            end
        end
    end

    assign stall_id        = w_stall;
    assign ex_valid        = r_ex_valid;
    assign control_rdata_a = r_sel_a;
    assign control_rdata_b = r_sel_b;
    assign state_lu        = (r_state == S_LU_BUBBLE);

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: expected post-edge outputs are queued per step
// and compared after the clock edge; stall_id is compared before the edge.
module tb_fwd_hazard_ctrl;

    localparam int unsigned AW = 5;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic          id_wreg;
    logic [AW-1:0] id_waddr;
    logic          id_is_load;
    logic          hold;
    logic          flush;
    logic          stall_id;
    logic          ex_valid;
    logic          control_rdata_a;
    logic          control_rdata_b;
    logic          state_lu;

    fwd_hazard_ctrl #(
        .REG_ADDR_W   (AW),
        .NUM_ZERO_REG (0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_wreg         (id_wreg),
        .id_waddr        (id_waddr),
        .id_is_load      (id_is_load),
        .hold            (hold),
        .flush           (flush),
        .stall_id        (stall_id),
        .ex_valid        (ex_valid),
        .control_rdata_a (control_rdata_a),
        .control_rdata_b (control_rdata_b),
        .state_lu        (state_lu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        logic  exv;
        logic  a;
        logic  b;
        logic  lu;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input string field, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, field, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic urs, input logic urt, input logic wr,
                         input logic [AW-1:0] wa, input logic ld);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_use_rs  = urs;
        id_use_rt  = urt;
        id_wreg    = wr;
        id_waddr   = wa;
        id_is_load = ld;
    endtask

    task automatic nop();
        drive(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    // Inputs are already driven; check stall_id, queue expected post-edge outputs, clock once.
    task automatic cyc(input string tag, input logic e_stall, input logic e_exv,
                       input logic e_a, input logic e_b, input logic e_lu);
        exp_t e;
        exp_t got;
        #1;
        chk(tag, "stall_id", stall_id, e_stall);
        e.tag = tag; e.exv = e_exv; e.a = e_a; e.b = e_b; e.lu = e_lu;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
        end else begin
            got = sb.pop_front();
            chk(got.tag, "ex_valid", ex_valid, got.exv);
            chk(got.tag, "sel_a", control_rdata_a, got.a);
            chk(got.tag, "sel_b", control_rdata_b, got.b);
            chk(got.tag, "state_lu", state_lu, got.lu);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        nop();
        @(negedge clk);

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 5'($urandom), 1'($urandom));
            hold  = 1'($urandom);
            flush = 1'($urandom);
            cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0; hold = 1'b0; flush = 1'b0;
        nop();
        cyc("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ALU dependency on rs, then hold freezes the asserted select
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
        cyc("alu_prod", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
        cyc("alu_cons", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        nop(); hold = 1'b1;
        cyc("alu_hold", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        hold = 1'b0;
        cyc("alu_nop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Load-use on rt: one bubble, then issue with select 0
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
        cyc("lu_load", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
        cyc("lu_stall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("lu_issue", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        nop();
        cyc("lu_nop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // $0 never forwarded or stalled, even behind a load to $0
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1);
        cyc("zero_prod", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd20, 1'b0);
        cyc("zero_cons", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Producer two ahead: no forward
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
        cyc("d2_prod", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
        cyc("d2_indep", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd21, 1'b0);
        cyc("d2_cons", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Both operands from the same producer
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0);
        cyc("both_prod", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd10, 5'd10, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0);
        cyc("both_cons", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // hold before and during the load-use bubble
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd11, 1'b1);
        cyc("hold_load", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd11, 5'd2, 1'b1, 1'b0, 1'b1, 5'd22, 1'b0);
        hold = 1'b1;
        cyc("hold_pend", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold = 1'b0;
        cyc("hold_stall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc("hold_bubble", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        hold = 1'b0;
        cyc("hold_issue", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        nop();
        cyc("hold_nop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // flush while a load-use hazard is pending
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd13, 1'b1);
        cyc("fl_load", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd2, 5'd13, 1'b1, 1'b1, 1'b1, 5'd24, 1'b0);
        flush = 1'b1;
        cyc("fl_lu", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        flush = 1'b0;
        nop();
        cyc("fl_nop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // flush suppresses a forward
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd14, 1'b0);
        cyc("flf_prod", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd14, 5'd2, 1'b1, 1'b1, 1'b1, 5'd25, 1'b0);
        flush = 1'b1;
        cyc("flf_cons", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        flush = 1'b0;

        // hold wins over flush; forward happens once both drop
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd15, 1'b0);
        cyc("hf_prod", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd15, 5'd2, 1'b1, 1'b1, 1'b1, 5'd23, 1'b0);
        hold = 1'b1; flush = 1'b1;
        cyc("hf_both", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        hold = 1'b0; flush = 1'b0;
        cyc("hf_issue", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // reset during the bubble
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd16, 1'b1);
        cyc("rb_load", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd16, 5'd2, 1'b1, 1'b0, 1'b1, 5'd26, 1'b0);
        cyc("rb_stall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        cyc("rb_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        nop();
        cyc("rb_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Forwarding and load-use hazard controller for the 5-stage MIPS core. Sits beside the ID/EX pipeline register and drives the EX-stage operand forwarding mux select lines control_rdata_a/control_rdata_b. It tracks destination-register info for the instructions in EX and MEM/WB, and decides per issued instruction whether each operand comes from mem_wb_dout. It also inserts a single bubble on load-use hazards.

Parameters:
REG_ADDR_W, 5, register address width
NUM_ZERO_REG, 0, hard-wired zero register index; never forwarded, never stalls

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_valid  in  1  valid instruction in ID
id_rs  in  REG_ADDR_W  ID source A address
id_rt  in  REG_ADDR_W  ID source B address
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_wreg  in  1  ID instruction writes a GPR
id_waddr  in  REG_ADDR_W  ID destination address
id_is_load  in  1  ID instruction is a load
hold  in  1  global pipeline freeze (memory wait)
flush  in  1  kill instructions in ID and EX (branch/exception)
stall_id  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  EX slot holds a real instruction (0 = bubble)
control_rdata_a  out  1  EX operand A select: 1 = mem_wb_dout
control_rdata_b  out  1  EX operand B select: 1 = mem_wb_dout
state_lu  out  1  debug: FSM in LU_BUBBLE

Behaviour:
- Internal slots: EX slot {valid, wreg, waddr, is_load}; MW slot {valid, wreg, waddr}. They advance on every clock edge with hold=0.
- Reset values: all slots invalid, ex_valid=0, control_rdata_a=0, control_rdata_b=0, state_lu=0. stall_id=0 while rst=1.
- Hit A = id_valid & id_use_rs & id_rs!=NUM_ZERO_REG & EX.valid & EX.wreg & EX.waddr==id_rs. Hit B is the same with rt.
- Load-use: stall_id = (hitA|hitB) & EX.is_load & !flush, combinational in the same cycle.
- Issue on an edge (hold=0, no stall, no flush):
  - EX slot <= ID info, valid=id_valid.
  - control_rdata_a <= hitA & !EX.is_load; control_rdata_b <= hitB & !EX.is_load.
  - MW slot <= old EX slot.
  - Latency of select is 1 cycle: the select is valid in the same cycle the instruction is in EX and the producer is in MEM/WB.
- Producer two or more stages ahead: no forward. The regfile is write-first.
- FSM states:
  - IDLE to LU_BUBBLE on stall_id=1 and hold=0. On that edge: EX slot <= bubble (valid=0), both selects <= 0, MW <= old EX (the load).
  - LU_BUBBLE to IDLE unconditionally on the next edge with hold=0. The stalled instruction re-evaluates in that cycle: EX is now the bubble, so no hit, so it issues with selects 0. The load data is picked up via the regfile.
  - Only one bubble per hazard.
- hold=1: all state, slots and outputs frozen. stall_id is still computed but has no effect on state.
- flush=1 (hold=0):
  - EX slot <= invalid, selects <= 0, FSM <= IDLE.
  - MW <= old EX slot, i.e. an instruction already past EX completes.
  - flush overrides stall_id.
- Simultaneous hold and flush: hold wins, and the flush must be reasserted.
- rst during LU_BUBBLE returns to IDLE with all outputs 0 on the next edge.
- Both operands hitting the same producer sets both selects.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0; ex_valid=0 after release until the first issue.
- ALU dependency: issue addu $3 (id_waddr=3, wreg=1), then addu with rs=3, rt=4 -> in the consumer's EX cycle control_rdata_a=1, control_rdata_b=0, stall_id never 1.
- Load-use: lw $5 then use rt=5 -> stall_id=1 for exactly 1 cycle, state_lu=1 for 1 cycle, ex_valid=0 (bubble), then the consumer issues with control_rdata_b=0.
- $0 and distance-2: a producer writing $0 followed by a consumer of $0 -> no forward, no stall. A producer, an independent instruction, then a consumer of the producer's register -> selects 0.
- hold: assert hold=1 for 3 cycles mid load-use stall -> state_lu, selects and ex_valid unchanged; completes with one bubble after release.
- flush: flush while a load-use hazard is pending -> stall_id=0, ex_valid=0, FSM IDLE, selects 0 on the next cycle.
